// File: rtl/count_pkg.sv
// Shared types and default sizes for the count-down timer.
//   cd_state_t : FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   CD_WIDTH   : default counter / reload width
//   CD_PW      : default prescale field width
package count_pkg;

  localparam int CD_WIDTH = 4;
  localparam int CD_PW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

endpackage

// File: rtl/count_down_timer_tick_gen.sv
// Prescaler for the count-down timer: emits one tick every prescale+1
// enabled cycles.
//   clk, reset_n : clock, async active-low reset
//   clear        : force the prescaler to 0 (wins over enable)
//   enable       : advance the prescaler; when low the count holds
//   prescale     : live compare value
//   tick         : combinational, high on the enabled cycle that hits the compare
module tick_gen
  import count_pkg::*;
#(
  parameter int PW = CD_PW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  logic [PW-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering prescale below the current count
  // fires on the next cycle instead of running the counter all the way round.
  // The increment cannot overflow: it only happens while cnt_q < prescale.
  always_comb begin
    tick  = enable && (cnt_q >= prescale);
    cnt_d = cnt_q;
    if (clear || tick) cnt_d = '0;
    else if (enable)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_down_timer.sv
// Loadable, prescaled down-counter with start/stop, terminal-count pulse
// and optional auto-reload.
//   clk, reset_n : clock, async active-low reset
//   load/load_val: capture a new reload value (and count); returns to IDLE
//   start / stop : run or resume / pause or abort (priority load > stop > start)
//   auto_reload  : live mode bit, sampled on each tick
//   prescale     : one tick every prescale+1 cycles, sampled live
//   q            : current count
//   busy / done  : state decode (RUN|PAUSE / DONE)
//   tc           : registered one-cycle pulse when q reaches 0
module count_down_timer
  import count_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH,
  parameter int PW    = CD_PW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [PW-1:0]    prescale,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             tick, pre_clear, pre_en;

  // A fresh start (from IDLE/DONE) or a load restarts the prescaler; a
  // resume from PAUSE deliberately does not. stop outranks start.
  assign pre_clear = load || (start && !stop && (state_q == IDLE || state_q == DONE));
  // Only RUN advances the prescaler; the stop cycle itself already holds it.
  assign pre_en    = (state_q == RUN) && !load && !stop;

  tick_gen #(.PW(PW)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (pre_clear),
    .enable   (pre_en),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (load) begin
      rld_d   = load_val;
      q_d     = load_val;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (start) begin
            q_d = rld_q;
            if (rld_q == '0) begin
              state_d = DONE;
              tc_d    = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (q_q > ONE) begin
              q_d = q_q - ONE;
            end else if (q_q == ONE) begin
              q_d  = '0;
              tc_d = 1'b1;
              if (!auto_reload) state_d = DONE;
            end else if (auto_reload) begin
              // Sitting at 0 in auto-reload: the reload tick closes the period.
              q_d  = rld_q;
              tc_d = (rld_q == '0);
            end else begin
              // auto_reload dropped while parked at 0: finish without a second tc.
              state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (stop)       state_d = IDLE;
          else if (start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == DONE);
  assign tc   = tc_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Directed bench for count_down_timer: inputs change 1ns after a rising
// edge, outputs are sampled at the same point.
module tb_count_down_timer;

  localparam int W = 4;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [P-1:0] prescale = '0;
  logic [W-1:0] q;
  logic         busy, done, tc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_down_timer #(.WIDTH(W), .PW(P)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .tc          (tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_val = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int tcs, tc_first, tc_last;

    // ---- reset state
    #12;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", tc, 0);
    reset_n = 1'b1;
    step();

    // ---- load 15, prescale 0, single shot
    prescale = 0; auto_reload = 0;
    do_load(15);
    chk("t1_load_q", q, 15);
    chk("t1_load_busy", busy, 0);
    do_start();
    chk("t1_start_q", q, 15);
    chk("t1_start_busy", busy, 1);
    for (int i = 14; i >= 1; i--) begin
      step();
      chk("t1_q", q, i);
      chk("t1_tc_low", tc, 0);
    end
    step();
    chk("t1_q0", q, 0);
    chk("t1_tc", tc, 1);
    chk("t1_done", done, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_hold_q", q, 0);
      chk("t1_hold_tc", tc, 0);
      chk("t1_hold_done", done, 1);
    end

    // ---- load 3, prescale 2, auto-reload, 24 cycles
    prescale = 2; auto_reload = 1;
    do_load(3);
    do_start();
    chk("t2_start_q", q, 3);
    tcs = 0; tc_first = -1; tc_last = -1;
    for (int c = 1; c <= 24; c++) begin
      step();
      chk("t2_q", q, 3 - ((c / 3) % 4));
      chk("t2_busy", busy, 1);
      if (tc === 1'b1) begin
        tcs++;
        if (tc_first < 0) tc_first = c;
        tc_last = c;
      end
    end
    chk("t2_tc_count", tcs, 2);
    chk("t2_tc_first", tc_first, 9);
    chk("t2_tc_gap", tc_last - tc_first, 12);

    // ---- pause / resume from 5
    prescale = 0; auto_reload = 0;
    do_load(9);
    do_start();
    for (int i = 0; i < 4; i++) step();
    chk("t3_q5", q, 5);
    do_stop();
    chk("t3_pause_q", q, 5);
    chk("t3_pause_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_q", q, 5);
      chk("t3_hold_busy", busy, 1);
    end
    do_start();
    chk("t3_resume_q", q, 5);
    step();
    chk("t3_q4", q, 4);
    step();
    chk("t3_q3", q, 3);

    // ---- second stop in PAUSE aborts to IDLE holding q
    do_load(9);
    do_start();
    for (int i = 0; i < 4; i++) step();
    do_stop();
    chk("t3b_pause_q", q, 5);
    do_stop();
    chk("t3b_idle_q", q, 5);
    chk("t3b_idle_busy", busy, 0);
    chk("t3b_idle_done", done, 0);

    // ---- load + start + stop together while running
    do_load(9);
    do_start();
    step();
    chk("t4_q8", q, 8);
    load = 1'b1; load_val = 7; start = 1'b1; stop = 1'b1;
    step();
    load = 1'b0; start = 1'b0; stop = 1'b0;
    chk("t4_q", q, 7);
    chk("t4_busy", busy, 0);
    chk("t4_tc", tc, 0);
    step();
    chk("t4_idle_q", q, 7);

    // ---- prescale lowered mid-run ticks on the next edge
    prescale = 10;
    do_load(5);
    do_start();
    for (int i = 0; i < 3; i++) step();
    chk("t5_slow_q", q, 5);
    prescale = 1;
    step();
    chk("t5_fast_q", q, 4);

    // ---- load 0 then start
    do_load(0);
    do_start();
    chk("t6_done", done, 1);
    chk("t6_tc", tc, 1);
    chk("t6_q", q, 0);
    chk("t6_busy", busy, 0);
    step();
    chk("t6_tc_drop", tc, 0);
    chk("t6_done_hold", done, 1);

    // ---- async reset mid-run
    prescale = 0;
    do_load(15);
    do_start();
    for (int i = 0; i < 3; i++) step();
    chk("t7_run_q", q, 12);
    reset_n = 1'b0;
    #2;
    chk("t7_rst_q", q, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_done", done, 0);
    chk("t7_rst_tc", tc, 0);
    step();
    chk("t7_rst_hold_q", q, 0);
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
